// File: rtl/gb_bus_ctrl.sv
// SM83 memory-bus sequencer: turns one bus request into one T_PER_M-clock M-cycle with
// address/strobe sequencing, bounded wait-state handling and registered read-back.
module gb_bus_ctrl #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned T_PER_M  = 4,   // legal range 3..15
  parameter int unsigned MAX_WAIT = 15   // 0 disables mem_wait
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,

  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_is_if,
  output logic              rsp_err,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_m1,
  input  logic              mem_wait
);

  localparam int unsigned TW = $clog2(T_PER_M + 1);
  localparam int unsigned WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [TW-1:0] TOne  = TW'(1);
  localparam logic [TW-1:0] TTwo  = TW'(2);
  localparam logic [TW-1:0] TWait = TW'(T_PER_M - 1);
  localparam logic [TW-1:0] TLast = TW'(T_PER_M);
  localparam logic [WW-1:0] WcMax = WW'(MAX_WAIT);
  localparam bit            WaitEn = (MAX_WAIT != 0);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  typedef enum logic [1:0] {
    OpIdle  = 2'd0,
    OpIf    = 2'd1,
    OpWrite = 2'd2,
    OpRead  = 2'd3
  } bus_opcode_t;

  state_e            state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [WW-1:0]     wc_q, wc_d;
  bus_opcode_t       op_q, op_d;
  logic              tmo_q, tmo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              is_if_q, is_if_d;
  logic              err_q, err_d;

  logic in_run, at_wait, at_last, accept, op_active;
  logic wait_hit, wait_hold, wait_tmo, capture;

  // Phase decode: everything here depends on registered state only, except the
  // accept/wait terms which feed next-state logic and never reach an output.
  always_comb begin
    in_run    = (state_q == StRun);
    at_wait   = in_run && (t_q == TWait);
    at_last   = in_run && (t_q == TLast);
    req_ready = (state_q == StIdle) || at_last;
    accept    = req_valid && req_ready;
    op_active = (op_q != OpIdle);
    wait_hit  = WaitEn && at_wait && op_active && mem_wait;
    wait_hold = wait_hit && (wc_q < WcMax);
    wait_tmo  = wait_hit && (wc_q == WcMax);
    capture   = at_wait && !wait_hold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      t_q     <= '0;
      wc_q    <= '0;
      op_q    <= OpIdle;
      tmo_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      is_if_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      wc_q    <= wc_d;
      op_q    <= op_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      is_if_q <= is_if_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    wc_d    = wc_q;
    op_d    = op_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    is_if_d = is_if_q;
    err_d   = err_q;

    if (accept) begin
      state_d = StRun;
      t_d     = TOne;
      wc_d    = '0;
      op_d    = bus_opcode_t'(req_op);
      tmo_d   = 1'b0;
      // An IDLE slot leaves the bus address/data where the previous op put them.
      if (bus_opcode_t'(req_op) != OpIdle) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
      end
    end else if (at_last) begin
      state_d = StIdle;
      t_d     = '0;
      wc_d    = '0;
    end else if (in_run) begin
      if (wait_hold) begin
        wc_d = wc_q + WW'(1);
      end else begin
        t_d = t_q + TOne;
        if (wait_tmo) begin
          tmo_d = 1'b1;
        end
      end
    end

    // Completion status is registered on the T_PER_M-1 -> T_PER_M step so it is
    // stable for the whole completion phase and holds until the next completion.
    if (capture) begin
      if (op_q == OpRead || op_q == OpIf) begin
        rdata_d = mem_rdata;
      end
      is_if_d = (op_q == OpIf);
      err_d   = tmo_q || wait_tmo;
    end
  end

  logic strobe_win;

  always_comb begin
    strobe_win = in_run && (t_q >= TTwo) && (t_q <= TWait);
    mem_rd     = strobe_win && (op_q == OpRead || op_q == OpIf);
    mem_wr     = strobe_win && (op_q == OpWrite);
    mem_m1     = in_run && (op_q == OpIf) && (t_q != TLast);
    rsp_valid  = at_last;
    rsp_rdata  = rdata_q;
    rsp_is_if  = is_if_q;
    rsp_err    = err_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
  end

endmodule

// File: tb/tb_gb_bus_ctrl.sv
// Directed bench for gb_bus_ctrl: default configuration, a MAX_WAIT=2 copy for the
// timeout case, and T_PER_M=3/15 wide-bus copies for the parameter sweep.
module tb_gb_bus_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared request side for the two 16/8 instances.
  logic        req_valid;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  mem_rdata;
  logic        wait_a, wait_b;

  logic        a_ready, a_rsp_valid, a_is_if, a_err, a_rd, a_wr, a_m1;
  logic [7:0]  a_rdata, a_wdata;
  logic [15:0] a_addr;
  logic        b_ready, b_rsp_valid, b_is_if, b_err, b_rd, b_wr, b_m1;
  logic [7:0]  b_rdata, b_wdata;
  logic [15:0] b_addr;

  // Shared request side for the two 24/16 instances.
  logic        w_valid;
  logic [1:0]  w_op;
  logic [23:0] w_addr;
  logic [15:0] w_wdata;
  logic [15:0] w_rdata;
  logic        w_wait;

  logic        c_ready, c_rsp_valid, c_is_if, c_err, c_rd, c_wr, c_m1;
  logic [15:0] c_rdata, c_wdata;
  logic [23:0] c_addr;
  logic        d_ready, d_rsp_valid, d_is_if, d_err, d_rd, d_wr, d_m1;
  logic [15:0] d_rdata, d_wdata;
  logic [23:0] d_addr;

  gb_bus_ctrl #(.ADDR_W(16), .DATA_W(8), .T_PER_M(4), .MAX_WAIT(15)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(a_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_is_if(a_is_if), .rsp_err(a_err),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(mem_rdata),
    .mem_rd(a_rd), .mem_wr(a_wr), .mem_m1(a_m1), .mem_wait(wait_a)
  );

  gb_bus_ctrl #(.ADDR_W(16), .DATA_W(8), .T_PER_M(4), .MAX_WAIT(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(b_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_is_if(b_is_if), .rsp_err(b_err),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(mem_rdata),
    .mem_rd(b_rd), .mem_wr(b_wr), .mem_m1(b_m1), .mem_wait(wait_b)
  );

  gb_bus_ctrl #(.ADDR_W(24), .DATA_W(16), .T_PER_M(3), .MAX_WAIT(15)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .req_valid(w_valid), .req_ready(c_ready), .req_op(w_op),
    .req_addr(w_addr), .req_wdata(w_wdata),
    .rsp_valid(c_rsp_valid), .rsp_rdata(c_rdata), .rsp_is_if(c_is_if), .rsp_err(c_err),
    .mem_addr(c_addr), .mem_wdata(c_wdata), .mem_rdata(w_rdata),
    .mem_rd(c_rd), .mem_wr(c_wr), .mem_m1(c_m1), .mem_wait(w_wait)
  );

  gb_bus_ctrl #(.ADDR_W(24), .DATA_W(16), .T_PER_M(15), .MAX_WAIT(15)) dut_d (
    .clk(clk), .rst_n(rst_n),
    .req_valid(w_valid), .req_ready(d_ready), .req_op(w_op),
    .req_addr(w_addr), .req_wdata(w_wdata),
    .rsp_valid(d_rsp_valid), .rsp_rdata(d_rdata), .rsp_is_if(d_is_if), .rsp_err(d_err),
    .mem_addr(d_addr), .mem_wdata(d_wdata), .mem_rdata(w_rdata),
    .mem_rd(d_rd), .mem_wr(d_wr), .mem_m1(d_m1), .mem_wait(w_wait)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int c_cnt, d_cnt, c_wcnt, d_wcnt, c_done, d_done;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; wait_a = 1'b0; wait_b = 1'b0;
    w_valid   = 1'b0; w_op = 2'd0; w_addr = '0; w_wdata = '0; w_rdata = '0; w_wait = 1'b0;
    #2;

    // Reset values.
    chk("rst_ready",  a_ready, 1);
    chk("rst_rspv",   a_rsp_valid, 0);
    chk("rst_rdata",  a_rdata, 0);
    chk("rst_is_if",  a_is_if, 0);
    chk("rst_err",    a_err, 0);
    chk("rst_addr",   a_addr, 0);
    chk("rst_wdata",  a_wdata, 0);
    chk("rst_strobe", {a_rd, a_wr, a_m1}, 0);
    chk("rst_c_addr", c_addr, 0);

    // Request presented during reset must not be accepted.
    req_valid = 1'b1; req_op = 2'd3; req_addr = 16'h1234;
    tick(); tick();
    chk("rst_req_addr", a_addr, 0);
    chk("rst_req_rd",   a_rd, 0);
    chk("rst_req_rspv", a_rsp_valid, 0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // READ 0xC000, no wait.
    req_valid = 1'b1; req_op = 2'd3; req_addr = 16'hC000; mem_rdata = 8'h5A;
    chk("rd_ready0", a_ready, 1);
    tick();  // cycle 1
    req_valid = 1'b0;
    chk("rd_addr_c1", a_addr, 16'hC000);
    chk("rd_rd_c1",   a_rd, 0);
    tick();  // cycle 2
    chk("rd_rd_c2",   a_rd, 1);
    chk("rd_ready_c2", a_ready, 0);
    tick();  // cycle 3
    chk("rd_rd_c3",   a_rd, 1);
    chk("rd_rspv_c3", a_rsp_valid, 0);
    tick();  // cycle 4
    chk("rd_rspv_c4", a_rsp_valid, 1);
    chk("rd_rdata",   a_rdata, 8'h5A);
    chk("rd_is_if",   a_is_if, 0);
    chk("rd_err",     a_err, 0);
    chk("rd_rd_c4",   a_rd, 0);
    tick();  // cycle 5
    chk("rd_rspv_c5", a_rsp_valid, 0);

    // Back-to-back IF 0x0100, WRITE 0xFF80<-0x3C, IDLE.
    req_valid = 1'b1; req_op = 2'd1; req_addr = 16'h0100; mem_rdata = 8'h11;
    tick();  // cycle 1
    req_valid = 1'b0;
    chk("if_m1_c1",   a_m1, 1);
    chk("if_rd_c1",   a_rd, 0);
    chk("if_addr_c1", a_addr, 16'h0100);
    tick();  // cycle 2
    chk("if_m1rd_c2", {a_m1, a_rd}, 2'b11);
    tick();  // cycle 3
    chk("if_m1rd_c3", {a_m1, a_rd}, 2'b11);
    tick();  // cycle 4
    chk("if_rspv_c4",  a_rsp_valid, 1);
    chk("if_is_if",    a_is_if, 1);
    chk("if_rdata",    a_rdata, 8'h11);
    chk("if_strb_c4",  {a_m1, a_rd, a_wr}, 0);
    chk("if_ready_c4", a_ready, 1);
    req_valid = 1'b1; req_op = 2'd2; req_addr = 16'hFF80; req_wdata = 8'h3C;
    tick();  // cycle 5
    req_valid = 1'b0;
    chk("wr_addr_c5",  a_addr, 16'hFF80);
    chk("wr_wdata_c5", a_wdata, 8'h3C);
    chk("wr_wr_c5",    a_wr, 0);
    chk("wr_rspv_c5",  a_rsp_valid, 0);
    tick();  // cycle 6
    chk("wr_wr_c6", {a_wr, a_rd, a_m1}, 3'b100);
    tick();  // cycle 7
    chk("wr_wr_c7", a_wr, 1);
    tick();  // cycle 8
    chk("wr_rspv_c8", a_rsp_valid, 1);
    chk("wr_is_if",   a_is_if, 0);
    chk("wr_rdata",   a_rdata, 8'h11);
    chk("wr_wr_c8",   a_wr, 0);
    req_valid = 1'b1; req_op = 2'd0; req_addr = 16'h1234; req_wdata = 8'hEE;
    tick();  // cycle 9
    req_valid = 1'b0;
    for (int k = 9; k <= 11; k++) begin
      chk("idle_strb",  {a_rd, a_wr, a_m1}, 0);
      chk("idle_addr",  a_addr, 16'hFF80);
      chk("idle_rspv",  a_rsp_valid, 0);
      tick();
    end
    // cycle 12
    chk("idle_rspv_c12", a_rsp_valid, 1);
    chk("idle_wdata",    a_wdata, 8'h3C);
    tick();

    // READ with mem_wait held for three clocks at t=3.
    req_valid = 1'b1; req_op = 2'd3; req_addr = 16'h8000;
    tick();  // cycle 1
    req_valid = 1'b0;
    tick();  // cycle 2
    tick();  // cycle 3
    wait_a = 1'b1; mem_rdata = 8'hEE;
    tick();  // cycle 4
    chk("wt_rd_c4",   a_rd, 1);
    chk("wt_rspv_c4", a_rsp_valid, 0);
    tick();  // cycle 5
    chk("wt_rd_c5",   a_rd, 1);
    chk("wt_rspv_c5", a_rsp_valid, 0);
    tick();  // cycle 6
    wait_a = 1'b0; mem_rdata = 8'h77;
    chk("wt_rd_c6",   a_rd, 1);
    tick();  // cycle 7
    chk("wt_rspv_c7", a_rsp_valid, 1);
    chk("wt_rdata",   a_rdata, 8'h77);
    chk("wt_err",     a_err, 0);
    tick();

    // Timeout on the MAX_WAIT=2 instance: WRITE with mem_wait stuck high.
    wait_b = 1'b1;
    req_valid = 1'b1; req_op = 2'd2; req_addr = 16'hA000; req_wdata = 8'h99;
    chk("to_ready0", b_ready, 1);
    tick();  // cycle 1
    req_valid = 1'b0;
    tick(); tick(); tick();  // cycle 4
    chk("to_rspv_c4", b_rsp_valid, 0);
    chk("to_wr_c4",   b_wr, 1);
    tick();  // cycle 5
    chk("to_rspv_c5", b_rsp_valid, 0);
    chk("to_wr_c5",   b_wr, 1);
    tick();  // cycle 6
    chk("to_rspv_c6", b_rsp_valid, 1);
    chk("to_err",     b_err, 1);
    chk("to_wr_c6",   b_wr, 0);
    wait_b = 1'b0;
    req_valid = 1'b1; req_op = 2'd3; req_addr = 16'h1111; mem_rdata = 8'h42;
    tick();  // next op cycle 1
    req_valid = 1'b0;
    tick(); tick();  // cycle 3
    chk("to_err_hold", b_err, 1);
    tick();  // cycle 4
    chk("to2_rspv", b_rsp_valid, 1);
    chk("to2_err",  b_err, 0);
    chk("to2_rdata", b_rdata, 8'h42);
    tick();

    // Reset during cycle 2 of a READ.
    req_valid = 1'b1; req_op = 2'd3; req_addr = 16'h5555; mem_rdata = 8'h24;
    tick();  // cycle 1
    req_valid = 1'b0;
    tick();  // cycle 2
    chk("mr_rd_pre", a_rd, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_rd",     a_rd, 0);
    chk("mr_addr",   a_addr, 0);
    chk("mr_rdata",  a_rdata, 0);
    chk("mr_ready",  a_ready, 1);
    chk("mr_rspv",   a_rsp_valid, 0);
    chk("mr_b_rdata", b_rdata, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_rspv_hold", a_rsp_valid, 0);
    end
    rst_n = 1'b1;
    chk("mr_ready_rel", a_ready, 1);
    req_valid = 1'b1; req_op = 2'd3; req_addr = 16'h2222; mem_rdata = 8'h33;
    tick();  // cycle 1
    req_valid = 1'b0;
    chk("mr2_addr", a_addr, 16'h2222);
    tick(); tick(); tick();  // cycle 4
    chk("mr2_rspv",  a_rsp_valid, 1);
    chk("mr2_rdata", a_rdata, 8'h33);
    tick();

    // Parameter sweep: T_PER_M=3 and 15 on a 24/16 bus, READ then WRITE.
    w_valid = 1'b1; w_op = 2'd3; w_addr = 24'hABCDEF; w_rdata = 16'hBEEF;
    chk("sw_ready", {c_ready, d_ready}, 2'b11);
    c_cnt = 0; d_cnt = 0; c_done = -1; d_done = -1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      w_valid = 1'b0;
      if (k == 1) begin
        chk("sw_c_addr", c_addr, 24'hABCDEF);
        chk("sw_d_addr", d_addr, 24'hABCDEF);
      end
      if (c_rd) c_cnt++;
      if (d_rd) d_cnt++;
      if (c_rsp_valid && c_done < 0) c_done = k;
      if (d_rsp_valid && d_done < 0) d_done = k;
    end
    chk("sw_c_rdcnt", c_cnt, 1);
    chk("sw_d_rdcnt", d_cnt, 13);
    chk("sw_c_done",  c_done, 3);
    chk("sw_d_done",  d_done, 15);
    chk("sw_c_rdata", c_rdata, 16'hBEEF);
    chk("sw_d_rdata", d_rdata, 16'hBEEF);

    w_valid = 1'b1; w_op = 2'd2; w_addr = 24'h123456; w_wdata = 16'hA5C3;
    c_wcnt = 0; d_wcnt = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      w_valid = 1'b0;
      if (k == 1) begin
        chk("sw_c_wdata", c_wdata, 16'hA5C3);
        chk("sw_d_wdata", d_wdata, 16'hA5C3);
        chk("sw_d_waddr", d_addr, 24'h123456);
      end
      if (c_wr) c_wcnt++;
      if (d_wr) d_wcnt++;
    end
    chk("sw_c_wrcnt", c_wcnt, 1);
    chk("sw_d_wrcnt", d_wcnt, 13);
    chk("sw_c_rdata_keep", c_rdata, 16'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_bus_ctrl.md
# gb_bus_ctrl

Parametrised memory-bus sequencer for the SM83 core. It sits between the control unit and the external memory/MMIO fabric, and turns one `bus_opcode_t` request (IDLE, IF, WRITE, READ) into one M-cycle of `T_PER_M` clocks. Each M-cycle drives the address, strobes and write data, honours device wait states with a timeout, and returns read data plus a completion strobe. Requests can be issued back-to-back at one M-cycle per `T_PER_M` clocks.

## Interface
Parameters:
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 8: data width.
- `T_PER_M`, default 4: clocks per M-cycle; legal range 3..15.
- `MAX_WAIT`, default 15: maximum consecutive wait clocks per M-cycle; 0 means `mem_wait` is ignored.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_op` in 2: `bus_opcode_t` encoding; IDLE=0, IF=1, WRITE=2, READ=3.
- `req_addr` in ADDR_W: address of the request.
- `req_wdata` in DATA_W: write data for WRITE.
- `rsp_valid` out 1: one-clock completion pulse.
- `rsp_rdata` out DATA_W: captured read data.
- `rsp_is_if` out 1: completed operation was IF.
- `rsp_err` out 1: completed operation hit the wait timeout.
- `mem_addr` out ADDR_W: bus address.
- `mem_wdata` out DATA_W: bus write data.
- `mem_rdata` in DATA_W: bus read data.
- `mem_rd` out 1: read strobe.
- `mem_wr` out 1: write strobe.
- `mem_m1` out 1: opcode-fetch marker.
- `mem_wait` in 1: device stall request.

## Operation
- **States.** The FSM has two states: `S_IDLE` and `S_RUN`. In `S_RUN`, a phase counter `t` runs 1..`T_PER_M` (width $clog2(T_PER_M+1)) and a wait counter `wc` runs 0..`MAX_WAIT`.
- **Accept.** A request is accepted when `req_valid && req_ready`.
  - `req_ready` = (state == `S_IDLE`) || (t == `T_PER_M` and `rsp_valid`).
  - On accept, the block latches `req_op`, `req_addr` and `req_wdata`, and goes to `S_RUN` with `t`=1 and `wc`=0.
- **End of M-cycle.** At `t`=`T_PER_M` with no new accept, the FSM returns to `S_IDLE`.
- **Phase t=1.**
  - `mem_addr` and `mem_wdata` take the latched values; they hold until the next accepted non-IDLE op.
  - `mem_m1` is 1 for IF during `t`=1..`T_PER_M`-1.
- **Phases t=2..T_PER_M-1.**
  - READ and IF: `mem_rd`=1.
  - WRITE: `mem_wr`=1.
  - IDLE op: no strobes, and `mem_addr`/`mem_wdata` are left unchanged.
- **Wait at t=T_PER_M-1.**
  - If `mem_wait`=1, the op is not IDLE, and `wc` < `MAX_WAIT`: `t` holds, `wc` increments, and the strobes stay asserted.
  - If `wc` == `MAX_WAIT` while `mem_wait` is still 1: `t` advances and the timeout flag is set.
- **Read capture.** On the clock where `t` advances from `T_PER_M`-1 to `T_PER_M`, READ and IF register `mem_rdata` into `rsp_rdata`. WRITE and IDLE leave `rsp_rdata` unchanged.
- **Completion.** In phase `t`=`T_PER_M`:
  - `rsp_valid`=1 and all strobes are 0.
  - `rsp_is_if` = (op == IF).
  - `rsp_err` = timeout flag.
  - `rsp_is_if` and `rsp_err` hold until the next completion.
- **Request inputs.** `req_*` inputs are ignored while `req_ready`=0.
- **Reset.** Assertion of `rst_n` takes effect immediately, in any state. Any in-flight M-cycle is dropped with no `rsp_valid`.

## Timing
- **Reset values.**
  - State `S_IDLE`, `t`=0, `wc`=0.
  - `req_ready`=1 and `rsp_valid`=0.
  - `rsp_rdata`=0, `rsp_is_if`=0, `rsp_err`=0.
  - `mem_addr`=0, `mem_wdata`=0.
  - `mem_rd`=0, `mem_wr`=0, `mem_m1`=0.
- **Requests during reset.** A request presented while `rst_n`=0 is not accepted.
- **Latency.** With an accept at cycle 0 and W wait clocks, `rsp_valid` is high in cycle `T_PER_M`+W.
- **Throughput.** Back-to-back accepts at `t`=`T_PER_M` give one M-cycle per `T_PER_M` clocks. The strobes drop to 0 for at least one clock (`t`=`T_PER_M`) between consecutive M-cycles.
- **Outputs.** All `mem_*` and `rsp_*` outputs are registered or decoded from registered state only; there is no combinational path from `mem_wait` or `mem_rdata` to any output.
- **Wait sampling.** `mem_wait` is sampled only in phase `t`=`T_PER_M`-1 and is ignored elsewhere.
- **Timeout.** With `MAX_WAIT`=N and `mem_wait` stuck high, the M-cycle lasts exactly `T_PER_M`+N clocks and completes with `rsp_err`=1.

## Test plan
- **READ, no wait.** `T_PER_M`=4. READ 0xC000 accepted at cycle 0, `mem_rdata`=0x5A.
  - Required: `mem_addr`=0xC000 from cycle 1; `mem_rd`=1 in cycles 2–3; `rsp_valid` in cycle 4 with `rsp_rdata`=0x5A, `rsp_is_if`=0, `rsp_err`=0.
- **Back-to-back IF, WRITE, IDLE.** IF 0x0100, then WRITE 0xFF80←0x3C, then IDLE, each accepted at its `t`=4.
  - Required: `rsp_valid` in cycles 4, 8 and 12.
  - IF: `mem_m1`=1 in cycles 1–3.
  - WRITE: `mem_wr`=1 in cycles 6–7 with `mem_wdata`=0x3C.
  - IDLE: no strobes, `mem_addr` stays 0xFF80.
- **Wait states.** READ with `mem_wait`=1 for 3 clocks at `t`=3.
  - Required: `mem_rd` held high through cycle 5; data captured when `mem_wait` drops; `rsp_valid` in cycle 7 with `rsp_err`=0.
- **Timeout.** `MAX_WAIT`=2, `mem_wait` stuck at 1 on a WRITE.
  - Required: `rsp_valid` in cycle 6 with `rsp_err`=1; the next op completes with `rsp_err`=0.
- **Reset mid-operation.** Assert `rst_n`=0 during cycle 2 of a READ.
  - Required: all outputs immediately take their reset values; no `rsp_valid`; after release, `req_ready`=1 and a new READ completes normally.
- **Parameter sweep.** `T_PER_M`=3 and 15, `ADDR_W`=24, `DATA_W`=16.
  - Required: strobe windows of 1 and 13 clocks respectively; full-width address and data pass through unchanged.
